// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
//
// Assigns incoming MIDI note events to one of NVOICE synth voices. Each event
// is accepted in IDLE, then the voices are examined one index per cycle in
// SCAN while the best candidates are tracked. One final resolve step applies
// the decision, enters COMMIT and raises the pulses. The result is a fixed
// 18-cycle turnaround per event.
//
// Note-on choice, in order of priority:
//   1. retrigger a held voice already playing the note
//   2. lowest-index voice that is neither held nor busy
//   3. steal the oldest voice (largest age, ties to the lowest index)
// Note-off releases the lowest-index held voice playing the note, if any.
//
// Ports
//   CLK                 system clock, rising edge
//   RST                 asynchronous active-high reset
//   ev_valid/ev_ready   event handshake; ready only in IDLE
//   ev_on/ev_note/ev_vel  event payload (note-on with vel 0 == note-off)
//   voice_busy          per-voice envelope-active flags, sampled during SCAN
//   new_note_pulse      one-hot start pulse, one cycle
//   release_note_pulse  one-hot release pulse, one cycle
//   voice_note          packed per-voice note, voice i at [7i+6:7i]
//   voice_vel           packed per-voice velocity, same packing
//   steal_pulse         high with new_note_pulse when a voice was stolen
// -----------------------------------------------------------------------------
module voice_allocator #(
  parameter int NVOICE = 16,
  parameter int AGE_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [6:0]            ev_note,
  input  logic [6:0]            ev_vel,
  input  logic [NVOICE-1:0]     voice_busy,
  output logic [NVOICE-1:0]     new_note_pulse,
  output logic [NVOICE-1:0]     release_note_pulse,
  output logic [7*NVOICE-1:0]   voice_note,
  output logic [7*NVOICE-1:0]   voice_vel,
  output logic                  steal_pulse
);

  localparam int IW = $clog2(NVOICE);
  // r_idx runs 0..NVOICE-1 while scanning; NVOICE marks the resolve step
  localparam logic [IW:0]      RESOLVE_IDX = (IW+1)'(NVOICE);
  localparam logic [AGE_W-1:0] AGE_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // latched event
  logic            r_ev_on;     // already folded: note-on with vel 0 is a note-off
  logic [6:0]      r_ev_note;
  logic [6:0]      r_ev_vel;

  // scan progress and running candidates
  logic [IW:0]     r_idx;
  logic            r_match_found;
  logic [IW-1:0]   r_match_idx;
  logic            r_free_found;
  logic [IW-1:0]   r_free_idx;
  logic [IW-1:0]   r_old_idx;
  logic [AGE_W-1:0] r_old_age;

  // per-voice state
  logic [6:0]       r_note [NVOICE];
  logic [6:0]       r_vel  [NVOICE];
  logic [AGE_W-1:0] r_age  [NVOICE];
  logic [NVOICE-1:0] r_held;

  // registered outputs
  logic [NVOICE-1:0] r_new_pulse;
  logic [NVOICE-1:0] r_rel_pulse;
  logic              r_steal;

  logic              w_scan_done;
  logic [IW-1:0]     w_idx;
  logic              w_match_here;
  logic              w_free_here;
  logic              w_older_here;
  logic [IW-1:0]     w_sel_idx;
  logic              w_steal;
  logic [NVOICE-1:0] w_sel_onehot;

  assign w_scan_done = (r_idx == RESOLVE_IDX);
  assign w_idx       = r_idx[IW-1:0];

  // examination of the voice at the current scan index
  assign w_match_here = r_held[w_idx] && (r_note[w_idx] == r_ev_note);
  assign w_free_here  = !r_held[w_idx] && !voice_busy[w_idx];
  // strict '>' keeps the lowest index on equal ages
  assign w_older_here = (r_idx == '0) || (r_age[w_idx] > r_old_age);

  // final choice; for note-off only the match candidate is meaningful
  always_comb begin
    w_sel_idx = r_old_idx;
    w_steal   = 1'b0;
    if (r_match_found) begin
      w_sel_idx = r_match_idx;
    end else if (r_free_found && r_ev_on) begin
      w_sel_idx = r_free_idx;
    end else if (r_ev_on) begin
      w_steal   = 1'b1;
    end
  end

  assign w_sel_onehot = {{(NVOICE-1){1'b0}}, 1'b1} << w_sel_idx;

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (ev_valid)    w_state_next = S_SCAN;
      S_SCAN:   if (w_scan_done) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ev_on       <= 1'b0;
      r_ev_note     <= '0;
      r_ev_vel      <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
      r_held        <= '0;
      r_new_pulse   <= '0;
      r_rel_pulse   <= '0;
      r_steal       <= 1'b0;
      for (int i = 0; i < NVOICE; i++) begin
        r_note[i] <= '0;
        r_vel[i]  <= '0;
        r_age[i]  <= '0;
      end
    end else begin
      // pulses are single-cycle by default
      r_new_pulse <= '0;
      r_rel_pulse <= '0;
      r_steal     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ev_valid) begin
            r_ev_on       <= ev_on && (ev_vel != 7'd0);
            r_ev_note     <= ev_note;
            r_ev_vel      <= ev_vel;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
          end
        end
        S_SCAN: begin
          if (!w_scan_done) begin
            if (w_match_here && !r_match_found) begin
              r_match_found <= 1'b1;
              r_match_idx   <= w_idx;
            end
            if (w_free_here && !r_free_found) begin
              r_free_found <= 1'b1;
              r_free_idx   <= w_idx;
            end
            if (w_older_here) begin
              r_old_idx <= w_idx;
              r_old_age <= r_age[w_idx];
            end
            r_idx <= r_idx + 1'b1;
          end else if (r_ev_on) begin
            r_new_pulse          <= w_sel_onehot;
            r_steal              <= w_steal;
            r_note[w_sel_idx]    <= r_ev_note;
            r_vel[w_sel_idx]     <= r_ev_vel;
            r_held[w_sel_idx]    <= 1'b1;
            for (int i = 0; i < NVOICE; i++) begin
              if (IW'(i) == w_sel_idx) begin
                r_age[i] <= '0;
              end else if (r_age[i] != AGE_MAX) begin
                r_age[i] <= r_age[i] + AGE_W'(1);
              end
            end
          end else if (r_match_found) begin
            r_rel_pulse          <= w_sel_onehot;
            r_held[r_match_idx]  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ev_ready           = (r_state == S_IDLE);
  assign new_note_pulse     = r_new_pulse;
  assign release_note_pulse = r_rel_pulse;
  assign steal_pulse        = r_steal;

  generate
    for (genvar gi = 0; gi < NVOICE; gi++) begin : g_pack
      assign voice_note[7*gi +: 7] = r_note[gi];
      assign voice_vel[7*gi +: 7]  = r_vel[gi];
    end
  endgenerate

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
//
// Directed scenarios followed by randomized events. A behavioural model of the
// allocation rules (plain arrays of note/velocity/age/held per voice) predicts
// the pulses and packed outputs of every event.
// -----------------------------------------------------------------------------
module tb_voice_allocator;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ev_valid;
  logic          ev_ready;
  logic          ev_on;
  logic [6:0]    ev_note;
  logic [6:0]    ev_vel;
  logic [15:0]   voice_busy;
  logic [15:0]   new_note_pulse;
  logic [15:0]   release_note_pulse;
  logic [111:0]  voice_note;
  logic [111:0]  voice_vel;
  logic          steal_pulse;

  voice_allocator #(.NVOICE(16), .AGE_W(8)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .ev_valid           (ev_valid),
    .ev_ready           (ev_ready),
    .ev_on              (ev_on),
    .ev_note            (ev_note),
    .ev_vel             (ev_vel),
    .voice_busy         (voice_busy),
    .new_note_pulse     (new_note_pulse),
    .release_note_pulse (release_note_pulse),
    .voice_note         (voice_note),
    .voice_vel          (voice_vel),
    .steal_pulse        (steal_pulse)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_note [16];
  int m_vel  [16];
  int m_age  [16];
  bit m_held [16];
  bit snap   [16];   // voice_busy as seen when each voice was examined
  int busy_mode;     // 0: mirror held, 1: all busy, 2: random each cycle

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_note[i] = 0;
      m_vel[i]  = 0;
      m_age[i]  = 0;
      m_held[i] = 1'b0;
    end
  endtask

  function automatic logic [15:0] held_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_held[i];
    return v;
  endfunction

  function automatic logic [111:0] exp_notes();
    logic [111:0] v;
    for (int i = 0; i < 16; i++) v[7*i +: 7] = 7'(m_note[i]);
    return v;
  endfunction

  function automatic logic [111:0] exp_vels();
    logic [111:0] v;
    for (int i = 0; i < 16; i++) v[7*i +: 7] = 7'(m_vel[i]);
    return v;
  endfunction

  task automatic drive_busy();
    case (busy_mode)
      0:       voice_busy = held_vec();
      1:       voice_busy = 16'hFFFF;
      default: voice_busy = 16'($urandom);
    endcase
  endtask

  // apply one event to the model and return the expected pulses
  task automatic model_event(input bit on, input int note, input int vel,
                             output logic [15:0] e_new, output logic [15:0] e_rel,
                             output logic e_steal);
    int  match;
    int  v;
    bit  eff_on;
    e_new   = '0;
    e_rel   = '0;
    e_steal = 1'b0;
    eff_on  = on && (vel != 0);
    match   = -1;
    for (int i = 0; i < 16; i++)
      if (match < 0 && m_held[i] && m_note[i] == note) match = i;
    if (eff_on) begin
      v = match;
      if (v < 0)
        for (int i = 0; i < 16; i++)
          if (v < 0 && !m_held[i] && !snap[i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 1; i < 16; i++)
          if (m_age[i] > m_age[v]) v = i;
        e_steal = 1'b1;
      end
      for (int i = 0; i < 16; i++) begin
        if (i == v)              m_age[i] = 0;
        else if (m_age[i] < 255) m_age[i] = m_age[i] + 1;
      end
      m_note[v] = note;
      m_vel[v]  = vel;
      m_held[v] = 1'b1;
      e_new     = 16'h0001 << v;
    end else if (match >= 0) begin
      m_held[match] = 1'b0;
      e_rel         = 16'h0001 << match;
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // one event: accept at edge E, scan, check at E+17 and E+18.
  // rst_at > 0 pulses RST just after edge E+rst_at.
  task automatic run_event(input bit on, input int note, input int vel, input int rst_at);
    int          guard;
    logic [15:0] e_new;
    logic [15:0] e_rel;
    logic        e_steal;
    bit          aborted;
    bit          early;
    guard = 0;
    while (ev_ready !== 1'b1 && guard < 40) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    check("ready_idle", ev_ready, 1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = 7'(note);
    ev_vel   = 7'(vel);
    drive_busy();
    @(posedge CLK);
    #1;
    // scramble the payload: the event must already be latched
    ev_note = 7'($urandom);
    ev_vel  = 7'($urandom);
    ev_on   = 1'($urandom);
    check("ready_low_scan", ev_ready, 0);
    aborted = 1'b0;
    early   = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      // stray valid while busy must be ignored
      ev_valid = (!aborted && k < 18) ? 1'($urandom) : 1'b0;
      drive_busy();
      @(posedge CLK);
      if (k <= 16) snap[k-1] = voice_busy[k-1];
      #1;
      if (k < 17 && ((|new_note_pulse) || (|release_note_pulse) || steal_pulse)) early = 1'b1;
      if (k == rst_at) begin
        RST = 1'b1;
        ev_valid = 1'b0;
        #1;
        aborted = 1'b1;
        model_reset();
        check("rst_ready", ev_ready, 1);
        check("rst_new", new_note_pulse, 0);
        check("rst_rel", release_note_pulse, 0);
        check("rst_note", voice_note, 0);
        check("rst_vel", voice_vel, 0);
        @(negedge CLK);
        RST = 1'b0;
      end
      if (k == 17) begin
        if (!aborted) begin
          model_event(on, note, vel, e_new, e_rel, e_steal);
        end else begin
          e_new = '0;
          e_rel = '0;
          e_steal = 1'b0;
        end
        check("new_pulse", new_note_pulse, e_new);
        check("rel_pulse", release_note_pulse, e_rel);
        check("steal", steal_pulse, e_steal);
        check("voice_note", voice_note, exp_notes());
        check("voice_vel", voice_vel, exp_vels());
      end
      if (k == 18) begin
        check("ready_e18", ev_ready, 1);
        check("new_clear", new_note_pulse, 0);
        check("rel_clear", release_note_pulse, 0);
      end
    end
    check("no_early_pulse", early, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    RST        = 1'b1;
    ev_valid   = 1'b0;
    ev_on      = 1'b0;
    ev_note    = '0;
    ev_vel     = '0;
    voice_busy = '0;
    busy_mode  = 0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check("reset_ready", ev_ready, 1);
    check("reset_new", new_note_pulse, 0);
    check("reset_rel", release_note_pulse, 0);
    check("reset_steal", steal_pulse, 0);
    check("reset_note", voice_note, 0);
    check("reset_vel", voice_vel, 0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // first note goes to voice 0
    run_event(1, 60, 100, 0);
    // second note to voice 1, release of 60 hits voice 0, unknown note-off is silent
    run_event(1, 64, 90, 0);
    run_event(0, 60, 0, 0);
    run_event(0, 61, 0, 0);

    // retrigger, then velocity-0 note-on acting as note-off
    do_reset();
    run_event(1, 60, 90, 0);
    run_event(1, 60, 20, 0);
    run_event(1, 60, 0, 0);

    // all voices busy: fill 16, then steal the oldest
    do_reset();
    busy_mode = 1;
    for (int i = 0; i < 16; i++) run_event(1, 40 + i, 50 + i, 0);
    run_event(1, 72, 99, 0);
    // keep retriggering one voice until the other ages saturate, then steal
    for (int i = 0; i < 250; i++) run_event(1, 55, 1 + (i % 120), 0);
    run_event(1, 90, 33, 0);

    // reset in the middle of a scan drops the event and clears held voices
    do_reset();
    busy_mode = 0;
    run_event(1, 60, 100, 0);
    run_event(1, 61, 80, 8);
    run_event(0, 60, 0, 0);

    // randomized events against the model
    busy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      bit on;
      int note;
      int vel;
      on   = ($urandom_range(0, 2) != 0);
      note = 60 + $urandom_range(0, 7);
      vel  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 127);
      run_event(on, note, vel, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
